// File: rtl/spi2apb3_pkg.sv
// Shared definitions for the SPI-to-APB3 bridge host: command bytes,
// frame geometry, host FSM encoding and the frame builder.
package spi2apb3_pkg;

    localparam int FRAME_BITS       = 112;
    localparam int RDATA_FIRST_EDGE = 80;

    localparam logic [7:0] CMD_APB_RD = 8'h20;
    localparam logic [7:0] CMD_APB_WR = 8'hA0;
    localparam logic [7:0] CMD_CFG_RD = 8'h40;
    localparam logic [7:0] CMD_CFG_WR = 8'hC0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_RESP  = 2'd3
    } host_state_t;

    // Map the 2-bit request opcode onto the bridge command byte.
    function automatic logic [7:0] op_to_cmd(input logic [1:0] op);
        logic [7:0] cmd;
        case (op)
            2'b00:   cmd = CMD_APB_RD;
            2'b01:   cmd = CMD_APB_WR;
            2'b10:   cmd = CMD_CFG_RD;
            default: cmd = CMD_CFG_WR;
        endcase
        return cmd;
    endfunction

    // Assemble the full frame; read ops (op[0]==0) carry a zero data field.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [1:0]  op,
                                                          input logic [31:0] addr,
                                                          input logic [31:0] wdata);
        logic [31:0] wfield;
        wfield = op[0] ? wdata : 32'h0;
        return {op_to_cmd(op), 8'h00, addr, wfield, 32'h0};
    endfunction

endpackage

// File: rtl/spi2apb3_sclk_gen.sv
// SPICLK divider: while run is high, SPICLK spends CLK_DIV PCLK cycles low
// then CLK_DIV cycles high. rise_en/fall_en are asserted in the cycle whose
// closing PCLK edge moves SPICLK 0->1 / 1->0. Dropping run parks SPICLK low.
module spi2apb3_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic run,
    output logic sclk,
    output logic rise_en,
    output logic fall_en
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             half_done;

    assign half_done = run && (div_cnt == DIV_LAST);
    assign rise_en   = half_done && !sclk;
    assign fall_en   = half_done && sclk;

    // Half-period counter and SPICLK level; restart from a low phase whenever run drops.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (!run) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (half_done) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi2apb3_host.sv
// SPI host for the SPI-to-APB3 bridge. Each accepted request is sent as one
// 112-bit frame MSB first, followed by an idle gap with SPICLK low and a
// one-cycle response pulse. Read data is collected from SPIDO on rising
// edges 80..111.
module spi2apb3_host #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [1:0]  REQ_OP,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    output logic        RSP_VALID,
    output logic [31:0] RSP_RDATA,
    output logic        BUSY,
    output logic        SPICLK,
    output logic        SPIDI,
    input  logic        SPIDO
);

    import spi2apb3_pkg::*;

    localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [6:0]       LAST_BIT = 7'(FRAME_BITS - 1);
    localparam logic [6:0]       FIRST_RD = 7'(RDATA_FIRST_EDGE);

    host_state_t           state;
    host_state_t           state_nxt;
    logic [FRAME_BITS-1:0] tx_shreg;
    logic [31:0]           rx_shreg;
    logic [6:0]            bit_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic                  run;
    logic                  sclk_rise;
    logic                  sclk_fall;
    logic                  accept;
    logic                  last_fall;
    logic                  gap_done;

    assign run       = (state == ST_SHIFT);
    assign accept    = REQ_VALID && (state == ST_IDLE);
    assign last_fall = sclk_fall && (bit_cnt == LAST_BIT);
    assign gap_done  = (state == ST_GAP) && (gap_cnt == GAP_LAST);

    spi2apb3_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .run     (run),
        .sclk    (SPICLK),
        .rise_en (sclk_rise),
        .fall_en (sclk_fall)
    );

    // FSM state register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake/status outputs. The frame ends on the falling
    // edge after the last rising edge, so SPICLK is already low in GAP.
    always_comb begin
        state_nxt = state;
        REQ_READY = 1'b0;
        BUSY      = 1'b1;
        RSP_VALID = 1'b0;
        case (state)
            ST_IDLE: begin
                REQ_READY = 1'b1;
                BUSY      = 1'b0;
                if (REQ_VALID) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (last_fall) state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (gap_done) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                RSP_VALID = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bit counter advances on each SPICLK fall, so during a bit's high half it
    // still names the rising edge just taken; the gap counter runs only in GAP.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            if (!run || last_fall) begin
                bit_cnt <= '0;
            end else if (sclk_fall) begin
                bit_cnt <= bit_cnt + 7'd1;
            end

            if ((state != ST_GAP) || gap_done) begin
                gap_cnt <= '0;
            end else begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

    // Transmit shift register: loaded on acceptance, shifted on each SPICLK
    // fall with zero fill. After 112 falls it is empty, which keeps SPIDI low
    // in GAP and IDLE without extra gating.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tx_shreg <= '0;
        end else if (accept) begin
            tx_shreg <= build_frame(REQ_OP, REQ_ADDR, REQ_WDATA);
        end else if (sclk_fall) begin
            tx_shreg <= {tx_shreg[FRAME_BITS-2:0], 1'b0};
        end
    end

    assign SPIDI = tx_shreg[FRAME_BITS-1];

    // Receive shift register: SPIDO sampled on the PCLK edge that raises SPICLK, edges 80..111.
    always_ff @(posedge PCLK) begin
        if (accept) begin
            rx_shreg <= '0;
        end else if (sclk_rise && (bit_cnt >= FIRST_RD)) begin
            rx_shreg <= {rx_shreg[30:0], SPIDO};
        end
    end

    // Response data: published together with RSP_VALID and held until the next response.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            RSP_RDATA <= '0;
        end else if (gap_done) begin
            RSP_RDATA <= rx_shreg;
        end
    end

endmodule
